// File: rtl/tap_sequencer.sv
// -----------------------------------------------------------------------------
// tap_sequencer
//   Generates five staggered timing strobes. An accepted start launches a
//   sequence of L = 5*STEP + W clocks. tap[k] rises STEP*(k+1) clocks after
//   the start edge and stays high for W clocks. W comes from len_sel, which is
//   latched when start is accepted.
//
// Parameters
//   STEP     clocks between successive tap rising edges (1..4)
//
// Ports
//   clk      input   sole clock, rising edge
//   reset    input   asynchronous active-high reset
//   start    input   request a sequence (level-sampled)
//   len_sel  input   pulse width select: 00=2, 01=4, 10=6, 11=8 clocks
//   hold     input   freeze an in-progress sequence
//   tap      output  timing strobes, tap[0] earliest
//   busy     output  sequence in progress
//   done     output  one-clock pulse at completion
//   overrun  output  one-clock pulse when start is rejected
// -----------------------------------------------------------------------------
module tap_sequencer #(
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] len_sel,
  input  logic       hold,
  output logic [4:0] tap,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Clocks from the start edge until the last tap rises.
  localparam logic [5:0] TAP_SPAN = 6'(5 * STEP);

  state_t     state_q, state_d;
  logic [5:0] c_q, c_d;
  logic [1:0] len_q, len_d;
  logic [4:0] tap_q, tap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;

  logic [5:0] c_inc;
  logic [5:0] width;
  logic [5:0] seq_len;

  // Pulse width in clocks: 2, 4, 6 or 8.
  function automatic logic [5:0] width_of(input logic [1:0] sel);
    return {3'b000, sel, 1'b0} + 6'd2;
  endfunction

  // Tap pattern for the cycle after the edge that brought the count to cnt.
  function automatic logic [4:0] tap_of(input logic [5:0] cnt, input logic [5:0] w);
    logic [4:0] t;
    logic [5:0] lo;
    t = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      lo   = 6'((k + 1) * STEP);
      t[k] = (cnt >= lo) && (cnt < (lo + w));
    end
    return t;
  endfunction

  assign c_inc   = c_q + 6'd1;
  assign width   = width_of(len_q);
  assign seq_len = TAP_SPAN + width;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    len_d     = len_q;
    tap_d     = tap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        // hold has no meaning until a sequence is running
        if (start) begin
          state_d = RUN;
          len_d   = len_sel;
          c_d     = 6'd0;
          tap_d   = 5'b00000;
          busy_d  = 1'b1;
        end else begin
          c_d    = 6'd0;
          tap_d  = 5'b00000;
          busy_d = 1'b0;
        end
      end

      RUN: begin
        if (hold) begin
          // Frozen: even the final edge is deferred, so any start is rejected.
          overrun_d = start;
        end else if (c_inc == seq_len) begin
          done_d = 1'b1;
          c_d    = 6'd0;
          tap_d  = 5'b00000;
          if (start) begin
            // The completing edge doubles as the next sequence's start edge.
            len_d  = len_sel;
            busy_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          c_d       = c_inc;
          tap_d     = tap_of(c_inc, width);
          overrun_d = start;
        end
      end

      default: begin
        state_d = IDLE;
        c_d     = 6'd0;
        tap_d   = 5'b00000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      c_q       <= 6'd0;
      len_q     <= 2'b00;
      tap_q     <= 5'b00000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      len_q     <= len_d;
      tap_q     <= tap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign tap     = tap_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tap_sequencer
//   Directed, table-driven bench for tap_sequencer. Two instances share clock,
//   reset, len_sel and hold: u_dut1 (STEP=1) and u_dut2 (STEP=2), each with its
//   own start. Each table record holds the inputs for one clock edge and the
//   outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_tap_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] len_sel = 2'b00;
  logic       hold = 1'b0;

  logic [4:0] tap1, tap2;
  logic       busy1, busy2, done1, done2, ov1, ov2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;    // 0 = u_dut1 (STEP=1), 1 = u_dut2 (STEP=2)
    logic       start;
    logic [1:0] len;
    logic       hold;
    logic [4:0] tap;
    logic [2:0] flags;  // {busy, done, overrun}
  } vec_t;

  vec_t vecs[$];

  tap_sequencer #(.STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .len_sel(len_sel), .hold(hold),
    .tap(tap1), .busy(busy1), .done(done1), .overrun(ov1)
  );

  tap_sequencer #(.STEP(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .len_sel(len_sel), .hold(hold),
    .tap(tap2), .busy(busy2), .done(done2), .overrun(ov2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got tap/busy/done/ovr=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic sel, input logic st, input logic [1:0] ln, input logic hd,
                     input logic [4:0] tp, input logic [2:0] fl);
    vec_t v;
    v.sel = sel; v.start = st; v.len = ln; v.hold = hd; v.tap = tp; v.flags = fl;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [7:0] act;
    @(negedge clk);
    start1  = v.sel ? 1'b0 : v.start;
    start2  = v.sel ? v.start : 1'b0;
    len_sel = v.len;
    hold    = v.hold;
    @(posedge clk);
    #1;
    act = v.sel ? {tap2, busy2, done2, ov2} : {tap1, busy1, done1, ov1};
    check($sformatf("vec%0d", idx), act, {v.tap, v.flags});
  endtask

  task automatic run_all();
    foreach (vecs[i]) apply(vecs[i], i);
  endtask

  // STEP=1, len_sel=00: W=2, L=7, one-clock start.
  task automatic add_basic();
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00000, 3'b100);  // E0
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);  // E1
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);  // E2
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00110, 3'b100);  // E3
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b01100, 3'b100);  // E4
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);  // E5
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);  // E6
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b010);  // E7 done
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b000);  // idle
  endtask

  initial begin
    // Reset state, including a start that arrives while reset is held.
    #2;
    check("reset_dut1", {tap1, busy1, done1, ov1}, 8'h00);
    check("reset_dut2", {tap2, busy2, done2, ov2}, 8'h00);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    check("start_in_reset", {tap1, busy1, done1, ov1}, 8'h00);
    @(negedge clk);
    start1 = 1'b0;
    reset  = 1'b0;

    add_basic();

    // Restart request at E3 is rejected; timing unchanged.
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00110, 3'b101);  // E3 overrun
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b01100, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b010);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b000);

    // Hold for 3 edges after E3 (hold ignored at the IDLE start edge).
    add(1'b0, 1'b1, 2'b00, 1'b1, 5'b00000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b1, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b1, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b1, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b01100, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b010);  // edge 10 done
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b000);

    // Hold at the final edge defers completion; start during it is rejected.
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b01100, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);
    add(1'b0, 1'b1, 2'b00, 1'b1, 5'b10000, 3'b101);  // deferred EL
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b010);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b000);

    // Start held high, len_sel=01 (W=4, L=9); len_sel wiggles mid-run.
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00000, 3'b100);  // E0
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00001, 3'b101);
    add(1'b0, 1'b1, 2'b11, 1'b0, 5'b00011, 3'b101);
    add(1'b0, 1'b1, 2'b11, 1'b0, 5'b00111, 3'b101);
    add(1'b0, 1'b1, 2'b10, 1'b0, 5'b01111, 3'b101);
    add(1'b0, 1'b1, 2'b11, 1'b0, 5'b11110, 3'b101);
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b11100, 3'b101);
    add(1'b0, 1'b1, 2'b11, 1'b0, 5'b11000, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b10000, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00000, 3'b110);  // E9 restart, len 01
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00001, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00011, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b00111, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b01111, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b11110, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b11100, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b11000, 3'b101);
    add(1'b0, 1'b1, 2'b01, 1'b0, 5'b10000, 3'b101);
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00000, 3'b110);  // E9 restart, len 00
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b00001, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b00011, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b00110, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b01100, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b11000, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b10000, 3'b100);
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 3'b010);  // E7 done
    add(1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 3'b000);

    // STEP=2, len_sel=11: W=8, L=18.
    add(1'b1, 1'b1, 2'b11, 1'b0, 5'b00000, 3'b100);  // E0
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b100);  // E1
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);  // E2
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);  // E4
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00111, 3'b100);  // E6
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00111, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b01111, 3'b100);  // E8
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b01111, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11110, 3'b100);  // E10
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11110, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11100, 3'b100);  // E12
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11100, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);  // E14
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b11000, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);  // E16
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b10000, 3'b100);
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b010);  // E18 done
    add(1'b1, 1'b0, 2'b00, 1'b0, 5'b00000, 3'b000);

    run_all();

    // Asynchronous reset while tap[2] is high (after E3), between edges.
    vecs.delete();
    add(1'b0, 1'b1, 2'b00, 1'b0, 5'b00000, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00001, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00011, 3'b100);
    add(1'b0, 1'b0, 2'b00, 1'b0, 5'b00110, 3'b100);
    run_all();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {tap1, busy1, done1, ov1}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_idle%0d", i), {tap1, busy1, done1, ov1}, 8'h00);
    end

    // A fresh sequence after reset behaves normally.
    vecs.delete();
    add_basic();
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
